// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB PWM controller: channel indices, duty word
// layout, FSM state encoding and the default prescaler divider.
package rgb_pkg;

    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;
    localparam int NUM_CH = 3;

    localparam int DUTY_CH_W  = 8;
    localparam int DUTY_R_LSB = 0;
    localparam int DUTY_G_LSB = 8;
    localparam int DUTY_B_LSB = 16;

    // 25 MHz / (97 * 256) gives a frame rate of about 1 kHz
    localparam int DIV_DEFAULT = 97;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Extract one channel's duty byte from the packed 24-bit duty word
    function automatic logic [DUTY_CH_W-1:0] duty_slice(input logic [23:0] word, input int ch);
        case (ch)
            CH_G:    return word[DUTY_G_LSB +: DUTY_CH_W];
            CH_B:    return word[DUTY_B_LSB +: DUTY_CH_W];
            default: return word[DUTY_R_LSB +: DUTY_CH_W];
        endcase
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: active duty register, optional slew toward the
// applied target, and the registered step comparator.
// Optional feature: RGB_PWM_CTRL_SLEW_EN moves the active duty by +/-1 per
// frame toward the target instead of jumping to it.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int STEPS_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               frame_start,
    input  logic               apply,
    input  logic [STEPS_W-1:0] duty_new,
    input  logic [STEPS_W-1:0] step,
    output logic               pwm,
    output logic               slewing
);

    logic [STEPS_W-1:0] active_q;
    logic [STEPS_W-1:0] active_nxt;

`ifdef RGB_PWM_CTRL_SLEW_EN
    logic [STEPS_W-1:0] target_q;
    logic [STEPS_W-1:0] target_nxt;

    // Target follows every applied word; active creeps one LSB per frame toward it
    always_comb begin
        target_nxt = apply ? duty_new : target_q;
        active_nxt = active_q;
        if (frame_start) begin
            if (active_q < target_nxt) begin
                active_nxt = active_q + 1'b1;
            end else if (active_q > target_nxt) begin
                active_nxt = active_q - 1'b1;
            end
        end
        slewing = (active_q != target_q);
    end

    // Target register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
        end else begin
            target_q <= target_nxt;
        end
    end
`else
    // Without slewing the applied word lands directly in the active register
    always_comb begin
        active_nxt = apply ? duty_new : active_q;
        slewing    = 1'b0;
    end
`endif

    // Active duty and comparator output; the comparator looks at the value
    // being loaded so a new duty shows on the pin one clock after frame_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            pwm      <= 1'b0;
        end else begin
            active_q <= active_nxt;
            pwm      <= run && (step < active_nxt);
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Three-channel RGB PWM controller: run/drain FSM, prescaler and step
// counter, and a single-slot duty handshake that is applied at frame
// boundaries so a frame never changes duty mid-way.
// Optional feature: RGB_PWM_CTRL_SLEW_EN (see pwm_channel).
module rgb_pwm_ctrl
    import rgb_pkg::*;
#(
    parameter int DIV     = DIV_DEFAULT,
    parameter int STEPS_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [23:0] duty_in,
    input  logic        duty_valid,
    output logic        duty_ready,
    output logic [2:0]  pwm_out,
    output logic        frame_start,
    output logic        busy
);

    localparam int                 PRESC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [STEPS_W-1:0] STEP_LAST  = '1;

    state_e              state_q;
    state_e              state_nxt;
    logic [PRESC_W-1:0]  presc_q;
    logic [STEPS_W-1:0]  step_q;
    logic                pending_q;
    logic [23:0]         pending_word_q;
    logic                running;
    logic                last_tick;
    logic                handshake;
    logic                apply;
    logic [NUM_CH-1:0]   slewing;

    assign running     = (state_q != IDLE);
    assign last_tick   = (presc_q == PRESC_LAST) && (step_q == STEP_LAST);
    assign frame_start = running && (presc_q == '0) && (step_q == '0);
    assign duty_ready  = !pending_q;
    assign handshake   = duty_valid && !pending_q;
    // In IDLE nothing is on the pins, so a pending word can land at once
    assign apply       = pending_q && (!running || frame_start);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next state and busy indication
    always_comb begin
        state_nxt = state_q;
        busy      = running || (|slewing);
        case (state_q)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (last_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Prescaler and step counter, parked at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            step_q  <= '0;
        end else if (!running) begin
            presc_q <= '0;
            step_q  <= '0;
        end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            step_q  <= step_q + 1'b1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Single-slot pending duty word; a same-cycle accept wins over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= 1'b0;
            pending_word_q <= '0;
        end else begin
            if (handshake) begin
                pending_q      <= 1'b1;
                pending_word_q <= duty_in;
            end else if (apply) begin
                pending_q      <= 1'b0;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        pwm_channel #(
            .STEPS_W (STEPS_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .run         (running),
            .frame_start (frame_start),
            .apply       (apply),
            .duty_new    (STEPS_W'(duty_slice(pending_word_q, ch))),
            .step        (step_q),
            .pwm         (pwm_out[ch]),
            .slewing     (slewing[ch])
        );
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 97, meaning clk cycles per PWM step (25 MHz / (97*256) ≈ 1007 Hz frame).
REQ-002 SHALL have parameter STEPS_W, default 8, meaning duty and PWM counter width (256 steps per frame).
REQ-003 SHALL have port clk, input, 1, meaning the 25 MHz system clock; it is the only clock.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, meaning PWM run request.
REQ-006 SHALL have port duty_in, input, 24, meaning the new duty word: [7:0] R, [15:8] G, [23:16] B.
REQ-007 SHALL have port duty_valid, input, 1, meaning duty_in is valid this cycle.
REQ-008 SHALL have port duty_ready, output, 1, meaning the pending slot is free.
REQ-009 SHALL have port pwm_out, output, 3, meaning the PWM outputs: bit0 R, bit1 G, bit2 B.
REQ-010 SHALL have port frame_start, output, 1, meaning a one-cycle pulse on the first step of every frame.
REQ-011 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-013 SHALL transition IDLE->RUN on enable=1; the prescaler and step counter SHALL start at 0 in the following cycle.
REQ-014 SHALL transition RUN->DRAIN when enable=0, and DRAIN->IDLE on the last tick of the current frame (step 255, prescaler DIV-1).
REQ-015 SHALL return DRAIN->RUN when enable=1 in DRAIN, without restarting the frame.
REQ-016 SHALL, in IDLE: pwm_out=0, counters held at 0, frame_start=0.
REQ-017 SHALL use a prescaler that counts 0..DIV-1 and wraps; the step counter SHALL increment on the wrap and wrap from 255 to 0.
REQ-018 SHALL drive pwm_out[i] high iff step < active[i] (registered), so that duty 0 gives constant low and duty 255 gives 255/256 high.
REQ-019 SHALL assert frame_start for the cycle in which step=0 and prescaler=0 in RUN, including the first cycle after entering RUN.
REQ-020 SHALL accept a handshake when duty_valid && duty_ready in the same cycle: duty_in is copied to the pending register and the pending flag is set.
REQ-021 SHALL drive duty_ready = !pending; duty_valid held while ready=0 SHALL be ignored, not queued.
REQ-022 SHALL, in RUN/DRAIN, copy pending to the active registers only in the frame_start cycle and clear the flag there, so that no mid-frame glitch occurs.
REQ-023 SHALL, in IDLE, copy pending to active on the next cycle.
REQ-024 SHALL, when a handshake and an apply occur in the same cycle, apply the old pending word and store the new one, leaving the flag set.
REQ-025 SHALL take effect on pwm_out from the frame_start cycle plus 1 clk after an active duty update.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously clear the state to IDLE, the counters, active, pending and the pending flag, and set pwm_out=0, frame_start=0, busy=0 and duty_ready=1.
REQ-027 SHALL treat reset asserted mid-frame as a full abort with no drain; the pending word SHALL be lost.

Configuration
REQ-028 SHALL use the macro RGB_PWM_CTRL_SLEW_EN: when defined, at each frame_start every active channel SHALL step by ±1 toward its target (the latest applied word) instead of jumping, and the pending→target copy SHALL still occur only at frame_start.
REQ-029 SHALL, when RGB_PWM_CTRL_SLEW_EN is defined, hold busy=1 while any active≠target, and DRAIN->IDLE SHALL still follow REQ-014.
REQ-030 SHALL, when RGB_PWM_CTRL_SLEW_EN is not defined, omit the target registers and apply active=pending directly.

Structure
REQ-031 SHALL place in the shared package rgb_pkg: the channel index constants CH_R=0, CH_G=1, CH_B=2, the duty word slice constants, the FSM state encoding, and the default DIV.
REQ-032 SHALL contain one sub-module, pwm_channel, comprising the active register, the optional slew logic and the comparator, instantiated 3 times; the FSM, prescaler and handshake SHALL stay in the top level.

Verification
REQ-033 SHALL verify with DIV=2: after reset, duty_ready=1 and pwm_out=0; with enable=1 and handshake 0x00FF80, R stays high 128 steps (256 clk), G stays high 255 steps, and B stays low, from the second frame onward.
REQ-034 SHALL verify that a handshake at step 100 of a frame leaves pwm_out unchanged until the next frame_start, with duty_ready=0 during the wait and 1 from frame_start+1.
REQ-035 SHALL verify that a second valid while ready=0 (word 0x111111) is dropped, and that the first word (0x222222) is the one applied.
REQ-036 SHALL verify that enable deasserted at step 10 leaves busy=1 until the end of step 255, then state=IDLE and pwm_out=0; re-enable at step 200 keeps RUN with no frame restart.
REQ-037 SHALL verify that rst_n pulsed low at step 50 with pending set clears pwm_out within the same cycle (async), and that pending is gone after release.
REQ-038 SHALL verify, with RGB_PWM_CTRL_SLEW_EN defined, that active R moving from 0 to target 5 reaches 5 after exactly 5 frame_starts, and that busy falls afterwards with enable=0.
